// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - opcodes, field slices, instruction types and pipeline-register structs
package mips32_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    // Least-significant bit of each instruction field
    localparam int OP_LSB = 26;
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;

    typedef enum logic [2:0] {
        RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP
    } instr_type_e;

    typedef enum logic [1:0] {
        FWD_NONE, FWD_EXMEM, FWD_MEMWB
    } fwd_sel_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ir;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        instr_type_e itype;
        logic [5:0]  op;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic        wr;
    } id_ex_t;

    typedef struct packed {
        logic        valid;
        instr_type_e itype;
        logic [31:0] result;
        logic [31:0] sdata;
        logic [4:0]  dst;
        logic        wr;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        instr_type_e itype;
        logic [31:0] result;
        logic [4:0]  dst;
        logic        wr;
    } mem_wb_t;

    function automatic instr_type_e decode(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
            OP_LW:                                         return LOAD;
            OP_SW:                                         return STORE;
            OP_BNEQZ, OP_BEQZ:                             return BRANCH;
            OP_HLT:                                        return HALT;
            default:                                       return NOP;
        endcase
    endfunction

endpackage

// File: rtl/mips32_hazard_unit.sv
// rtl/mips32_hazard_unit.sv - combinational interlock, flush and operand-bypass selection
module mips32_hazard_unit
    import mips32_pkg::*;
#(
    parameter int FORWARDING = 1
) (
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic       ex_valid,
    input  logic       ex_wr,
    input  logic       ex_load,
    input  logic [4:0] ex_dst,
    input  logic       mem_valid,
    input  logic       mem_wr,
    input  logic       mem_load,
    input  logic [4:0] mem_dst,
    input  logic       wb_valid,
    input  logic       wb_wr,
    input  logic [4:0] wb_dst,
    input  logic       branch_taken,
    output logic       stall,
    output logic       flush,
    output fwd_sel_e   fwd_a,
    output fwd_sel_e   fwd_b
);

    logic ex_hit;
    logic mem_hit;

    // Does the instruction in ID read a register produced by EX or MEM
    always_comb begin
        ex_hit  = ex_valid && ex_wr &&
                  ((id_use_rs && ex_dst == id_rs) || (id_use_rt && ex_dst == id_rt));
        mem_hit = mem_valid && mem_wr &&
                  ((id_use_rs && mem_dst == id_rs) || (id_use_rt && mem_dst == id_rt));
    end

    // Stall: with bypass only a load feeding the next instruction; without, any pending producer
    always_comb begin
        flush = branch_taken;
        if (FORWARDING != 0) begin
            stall = id_valid && ex_hit && ex_load;
        end else begin
            stall = id_valid && (ex_hit || mem_hit);
        end
    end

    // Bypass select for EX operands; the younger producer in EX/MEM takes priority
    always_comb begin
        fwd_a = FWD_NONE;
        fwd_b = FWD_NONE;
        if (FORWARDING != 0) begin
            if (mem_valid && mem_wr && !mem_load && mem_dst == ex_rs) begin
                fwd_a = FWD_EXMEM;
            end else if (wb_valid && wb_wr && wb_dst == ex_rs) begin
                fwd_a = FWD_MEMWB;
            end
            if (mem_valid && mem_wr && !mem_load && mem_dst == ex_rt) begin
                fwd_b = FWD_EXMEM;
            end else if (wb_valid && wb_wr && wb_dst == ex_rt) begin
                fwd_b = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/mips32_pipe_interlock.sv
// rtl/mips32_pipe_interlock.sv - five-stage MIPS32 core with hardware interlock and optional bypass
module mips32_pipe_interlock
    import mips32_pkg::*;
#(
    parameter int          MEM_DEPTH  = 1024,
    parameter int          NUM_REGS   = 32,
    parameter int          FORWARDING = 1,
    parameter logic [31:0] RESET_PC   = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        halted,
    output logic [31:0] pc_out,
    output logic [31:0] retire_count,
    output logic [31:0] stall_count
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // Unified instruction/data memory and register file; never reset, preloaded by the bench
    logic [31:0] Mem [MEM_DEPTH];
    logic [31:0] Reg [NUM_REGS];

    logic [31:0] pc;
    logic        halt_seen;
    if_id_t      if_id;
    id_ex_t      id_ex;
    ex_mem_t     ex_mem;
    mem_wb_t     mem_wb;

    id_ex_t      id_next;
    ex_mem_t     ex_next;
    mem_wb_t     wb_next;
    instr_type_e id_type;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        id_use_rs, id_use_rt;
    logic        id_is_halt, fetch_en;
    logic [31:0] op_a, op_b, alu, br_target;
    logic        branch_taken;
    logic        stall, flush;
    fwd_sel_e    fwd_a, fwd_b;
    logic [31:0] fetch_word, mem_rdata;

    function automatic logic [AW-1:0] mem_idx(input logic [31:0] addr);
        return AW'(addr % 32'(MEM_DEPTH));
    endfunction

    // Register read with R0 and out-of-range indices forced to 0 and WB write-through
    function automatic logic [31:0] read_reg(input logic [4:0] r);
        if (r == 5'd0 || int'(r) >= NUM_REGS) begin
            return 32'd0;
        end else if (mem_wb.valid && mem_wb.wr && mem_wb.dst == r) begin
            return mem_wb.result;
        end else begin
            return Reg[r];
        end
    endfunction

    assign pc_out     = pc;
    assign fetch_word = Mem[mem_idx(pc)];
    assign mem_rdata  = Mem[mem_idx(ex_mem.result)];

    // ID: decode, register read and destination selection
    always_comb begin
        id_type    = decode(if_id.ir[OP_LSB +: 6]);
        id_rs      = if_id.ir[RS_LSB +: 5];
        id_rt      = if_id.ir[RT_LSB +: 5];
        id_dst     = (id_type == RR_ALU) ? if_id.ir[RD_LSB +: 5] : id_rt;
        id_use_rs  = id_type inside {RR_ALU, RM_ALU, LOAD, STORE, BRANCH};
        id_use_rt  = id_type inside {RR_ALU, STORE};
        id_is_halt = if_id.valid && id_type == HALT;
        fetch_en   = !halt_seen && !id_is_halt;
        id_next       = '0;
        id_next.valid = if_id.valid;
        id_next.itype = id_type;
        id_next.op    = if_id.ir[OP_LSB +: 6];
        id_next.pc    = if_id.pc;
        id_next.a     = read_reg(id_rs);
        id_next.b     = read_reg(id_rt);
        id_next.imm   = {{16{if_id.ir[15]}}, if_id.ir[15:0]};
        id_next.rs    = id_rs;
        id_next.rt    = id_rt;
        id_next.dst   = id_dst;
        id_next.wr    = (id_type inside {RR_ALU, RM_ALU, LOAD}) && id_dst != 5'd0 &&
                        int'(id_dst) < NUM_REGS;
    end

    mips32_hazard_unit #(.FORWARDING(FORWARDING)) hazard (
        .id_valid     (if_id.valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .ex_rs        (id_ex.rs),
        .ex_rt        (id_ex.rt),
        .ex_valid     (id_ex.valid),
        .ex_wr        (id_ex.wr),
        .ex_load      (id_ex.itype == LOAD),
        .ex_dst       (id_ex.dst),
        .mem_valid    (ex_mem.valid),
        .mem_wr       (ex_mem.wr),
        .mem_load     (ex_mem.itype == LOAD),
        .mem_dst      (ex_mem.dst),
        .wb_valid     (mem_wb.valid),
        .wb_wr        (mem_wb.wr),
        .wb_dst       (mem_wb.dst),
        .branch_taken (branch_taken),
        .stall        (stall),
        .flush        (flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

    // EX: operand bypass, ALU, branch resolution
    always_comb begin
        case (fwd_a)
            FWD_EXMEM: op_a = ex_mem.result;
            FWD_MEMWB: op_a = mem_wb.result;
            default:   op_a = id_ex.a;
        endcase
        case (fwd_b)
            FWD_EXMEM: op_b = ex_mem.result;
            FWD_MEMWB: op_b = mem_wb.result;
            default:   op_b = id_ex.b;
        endcase
        alu = '0;
        case (id_ex.itype)
            RR_ALU: begin
                case (id_ex.op)
                    OP_ADD:  alu = op_a + op_b;
                    OP_SUB:  alu = op_a - op_b;
                    OP_AND:  alu = op_a & op_b;
                    OP_OR:   alu = op_a | op_b;
                    OP_SLT:  alu = {31'd0, $signed(op_a) < $signed(op_b)};
                    OP_MUL:  alu = op_a * op_b;
                    default: alu = '0;
                endcase
            end
            RM_ALU: begin
                case (id_ex.op)
                    OP_ADDI: alu = op_a + id_ex.imm;
                    OP_SUBI: alu = op_a - id_ex.imm;
                    OP_SLTI: alu = {31'd0, $signed(op_a) < $signed(id_ex.imm)};
                    default: alu = '0;
                endcase
            end
            LOAD, STORE: alu = op_a + id_ex.imm;
            default:     alu = '0;
        endcase
        branch_taken = id_ex.valid && id_ex.itype == BRANCH &&
                       ((id_ex.op == OP_BEQZ) ? (op_a == 32'd0) : (op_a != 32'd0));
        br_target    = id_ex.pc + 32'd1 + id_ex.imm;
        ex_next        = '0;
        ex_next.valid  = id_ex.valid;
        ex_next.itype  = id_ex.itype;
        ex_next.result = alu;
        ex_next.sdata  = op_b;
        ex_next.dst    = id_ex.dst;
        ex_next.wr     = id_ex.wr;
    end

    // MEM: loads take the memory word, everything else passes the ALU result
    always_comb begin
        wb_next        = '0;
        wb_next.valid  = ex_mem.valid;
        wb_next.itype  = ex_mem.itype;
        wb_next.result = (ex_mem.itype == LOAD) ? mem_rdata : ex_mem.result;
        wb_next.dst    = ex_mem.dst;
        wb_next.wr     = ex_mem.wr;
    end

    // Pipeline advance; flush beats stall, and everything freezes once halted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            halt_seen    <= 1'b0;
            halted       <= 1'b0;
            retire_count <= '0;
            stall_count  <= '0;
            if_id        <= '0;
            id_ex        <= '0;
            ex_mem       <= '0;
            mem_wb       <= '0;
        end else if (!halted) begin
            ex_mem <= ex_next;
            mem_wb <= wb_next;
            if (mem_wb.valid) begin
                retire_count <= retire_count + 32'd1;
            end
            if (mem_wb.valid && mem_wb.itype == HALT) begin
                halted <= 1'b1;
            end
            if (flush) begin
                pc    <= br_target;
                if_id <= '0;
                id_ex <= '0;
            end else if (stall) begin
                id_ex       <= '0;
                stall_count <= stall_count + 32'd1;
            end else begin
                id_ex <= id_next;
                if (id_is_halt) begin
                    halt_seen <= 1'b1;
                end
                if (fetch_en) begin
                    if_id <= '{valid: 1'b1, pc: pc, ir: fetch_word};
                    pc    <= pc + 32'd1;
                end else begin
                    if_id <= '0;
                end
            end
        end
    end

    // Architectural writes: store in MEM, register writeback in WB
    always_ff @(posedge clk) begin
        if (rst_n && !halted && ex_mem.valid && ex_mem.itype == STORE) begin
            Mem[mem_idx(ex_mem.result)] <= ex_mem.sdata;
        end
        if (rst_n && !halted && mem_wb.valid && mem_wb.wr) begin
            Reg[mem_wb.dst] <= mem_wb.result;
        end
    end

endmodule

// File: tb/tb_mips32_pipe_interlock.sv
// tb/tb_mips32_pipe_interlock.sv - self-checking bench running both bypass variants side by side
module tb_mips32_pipe_interlock;
    import mips32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        halted_f, halted_n;
    logic [31:0] pc_f, pc_n, ret_f, ret_n, stl_f, stl_n;

    always #5 clk = ~clk;

    mips32_pipe_interlock #(.FORWARDING(1)) mips (
        .clk(clk), .rst_n(rst_n), .halted(halted_f), .pc_out(pc_f),
        .retire_count(ret_f), .stall_count(stl_f)
    );

    mips32_pipe_interlock #(.FORWARDING(0)) mips_nf (
        .clk(clk), .rst_n(rst_n), .halted(halted_n), .pc_out(pc_n),
        .retire_count(ret_n), .stall_count(stl_n)
    );

    // stall: >=0 exact, -1 don't care, -2 must exceed 1
    typedef struct {
        int          prog;
        int          chk_reg;
        int          addr;
        logic [31:0] val;
        int          retire;
        int          stall;
        int          pc;
    } vec_t;

    vec_t vecs[8];
    vec_t q_f[$];
    vec_t q_n[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic put(input int a, input logic [31:0] w);
        mips.Mem[a]    = w;
        mips_nf.Mem[a] = w;
    endtask

    task automatic set_reg(input int r, input logic [31:0] v);
        mips.Reg[r]    = v;
        mips_nf.Reg[r] = v;
    endtask

    task automatic load_prog(input int p);
        logic [31:0] hlt;
        hlt = {OP_HLT, 26'd0};
        for (int i = 0; i < 1024; i++) put(i, 32'd0);
        for (int r = 0; r < 32; r++) set_reg(r, 32'd0);
        case (p)
            0: begin
                put(0, ri(OP_ADDI, 1, 0, 120));
                put(1, ri(OP_LW, 2, 1, 0));
                put(2, ri(OP_ADDI, 2, 2, 45));
                put(3, ri(OP_SW, 2, 1, 1));
                put(4, hlt);
                put(120, 32'd85);
            end
            1: begin
                put(0, ri(OP_ADDI, 2, 0, 1));
                put(1, ri(OP_LW, 3, 10, 0));
                put(2, rr(OP_MUL, 2, 2, 3));
                put(3, ri(OP_SUBI, 3, 3, 1));
                put(4, ri(OP_BNEQZ, 0, 3, -3));
                put(5, ri(OP_SW, 2, 10, -2));
                put(6, hlt);
                set_reg(10, 32'd200);
                put(200, 32'd7);
            end
            2: begin
                put(0, ri(OP_BEQZ, 0, 0, 1));
                put(1, hlt);
                put(2, ri(OP_ADDI, 4, 0, 9));
                put(3, hlt);
            end
            default: begin
                put(0, ri(OP_ADDI, 0, 0, 5));
                put(1, rr(OP_ADD, 4, 0, 0));
                put(2, hlt);
                set_reg(4, 32'd77);
            end
        endcase
    endtask

    task automatic score(input int fwd, input vec_t v);
        logic [31:0] val, ret, stl, pcv;
        string tag;
        tag = $sformatf("p%0d_fwd%0d", v.prog, fwd);
        if (fwd == 1) begin
            val = (v.chk_reg != 0) ? mips.Reg[v.addr] : mips.Mem[v.addr];
            ret = ret_f; stl = stl_f; pcv = pc_f;
        end else begin
            val = (v.chk_reg != 0) ? mips_nf.Reg[v.addr] : mips_nf.Mem[v.addr];
            ret = ret_n; stl = stl_n; pcv = pc_n;
        end
        check({tag, "_value"}, val, v.val);
        check({tag, "_retire"}, ret, 32'(v.retire));
        check({tag, "_pc"}, pcv, 32'(v.pc));
        if (v.stall >= 0) begin
            check({tag, "_stall"}, stl, 32'(v.stall));
        end else if (v.stall == -2) begin
            check({tag, "_stall_gt1"}, 32'(stl > 32'd1), 32'd1);
        end
    endtask

    // Queue the expectations, release reset and score each core when its halted flag rises
    task automatic wait_halt(input int p);
        bit done_f, done_n;
        done_f = 0;
        done_n = 0;
        q_f.push_back(vecs[2*p]);
        q_n.push_back(vecs[2*p+1]);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 600 && !(done_f && done_n); c++) begin
            @(negedge clk);
            if (halted_f && !done_f) begin
                done_f = 1;
                score(1, q_f.pop_front());
            end
            if (halted_n && !done_n) begin
                done_n = 1;
                score(0, q_n.pop_front());
            end
        end
        check($sformatf("p%0d_fwd1_halt_seen", p), 32'(done_f), 32'd1);
        check($sformatf("p%0d_fwd0_halt_seen", p), 32'(done_n), 32'd1);
        q_f.delete();
        q_n.delete();
        repeat (5) @(negedge clk);
        check($sformatf("p%0d_fwd1_retire_frozen", p), ret_f, 32'(vecs[2*p].retire));
        check($sformatf("p%0d_fwd0_pc_frozen", p), pc_n, 32'(vecs[2*p+1].pc));
    endtask

    initial begin
        vecs[0] = '{0, 0, 121, 32'd130,  5,  1, 5};
        vecs[1] = '{0, 0, 121, 32'd130,  5, -2, 5};
        vecs[2] = '{1, 0, 198, 32'd5040, 25, 1, 7};
        vecs[3] = '{1, 0, 198, 32'd5040, 25, -1, 7};
        vecs[4] = '{2, 1, 4,   32'd9,    3,  0, 4};
        vecs[5] = '{2, 1, 4,   32'd9,    3,  0, 4};
        vecs[6] = '{3, 1, 4,   32'd0,    3,  0, 3};
        vecs[7] = '{3, 1, 4,   32'd0,    3,  0, 3};

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_halted", 32'(halted_f), 32'd0);
        check("reset_pc", pc_f, 32'd0);
        check("reset_retire", ret_f, 32'd0);
        check("reset_stall", stl_n, 32'd0);

        for (int p = 0; p < 4; p++) begin
            rst_n = 1'b0;
            load_prog(p);
            repeat (2) @(negedge clk);
            wait_halt(p);
        end

        // Reset pulled asynchronously in the middle of the factorial loop
        rst_n = 1'b0;
        load_prog(1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("midrun_not_halted", 32'(halted_f), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_halted_f", 32'(halted_f), 32'd0);
        check("async_pc_f", pc_f, 32'd0);
        check("async_retire_f", ret_f, 32'd0);
        check("async_stall_f", stl_f, 32'd0);
        check("async_halted_n", 32'(halted_n), 32'd0);
        check("async_pc_n", pc_n, 32'd0);
        check("async_retire_n", ret_n, 32'd0);
        check("async_stall_n", stl_n, 32'd0);
        repeat (3) @(negedge clk);
        check("reset_no_store_f", mips.Mem[198], 32'd0);
        check("reset_no_store_n", mips_nf.Mem[198], 32'd0);
        wait_halt(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
